// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the MEM->WB writeback slice.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam logic [4:0]  REG_ZERO   = 5'd0;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Little-endian lane select and sign/zero extension of raw load data.
module load_align
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] mem,
  input  logic [1:0]        addr_lo,
  input  ld_size_e          size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem[{addr_lo, 3'b000} +: 8];
    half_lane = mem[{addr_lo[1], 4'b0000} +: 16];
    data      = mem;
    misalign  = 1'b0;
    case (size)
      LD_BYTE: data = {{(DATA_W-8){~is_unsigned & byte_lane[7]}}, byte_lane};
      LD_HALF: begin
        data     = {{(DATA_W-16){~is_unsigned & half_lane[15]}}, half_lane};
        misalign = addr_lo[0];
      end
      // reserved size behaves as a full word
      default: misalign = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// One-entry MEM->WB stage: register file write port, decode bypass,
// retire counter and sticky misaligned-load flag.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dest_5,
  input  logic              in_wen,
  input  logic              in_is_load,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [1:0]        in_addr_lo_2,
  input  logic [DATA_W-1:0] in_alu_32,
  input  logic [DATA_W-1:0] in_mem_32,
  input  logic              wb_hold,
  output logic [ADDR_W-1:0] rf_address_d_5,
  output logic [DATA_W-1:0] rf_data_dval_32,
  output logic              rf_w_en,
  input  logic [ADDR_W-1:0] byp_s1_addr_5,
  input  logic [ADDR_W-1:0] byp_s2_addr_5,
  output logic              byp_s1_hit,
  output logic [DATA_W-1:0] byp_s1_val_32,
  output logic              byp_s2_hit,
  output logic [DATA_W-1:0] byp_s2_val_32,
  output logic [CNT_W-1:0]  retire_count_32,
  output logic              misalign_err
);

  wb_state_e         state;
  logic [ADDR_W-1:0] st_dest;
  logic              st_wen;
  logic              st_mis;
  logic [DATA_W-1:0] st_data;

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  logic              full;
  logic              commit;
  logic              accept;
  logic              in_mis;
  logic              st_live;

  load_align #(.DATA_W(DATA_W)) u_align (
    .mem         (in_mem_32),
    .addr_lo     (in_addr_lo_2),
    .size        (ld_size_e'(in_ld_size)),
    .is_unsigned (in_ld_unsigned),
    .data        (ld_data),
    .misalign    (ld_mis)
  );

  assign full     = (state == FULL);
  assign commit   = full & ~wb_hold;
  assign in_ready = ~full | commit;
  assign accept   = in_valid & in_ready;
  assign in_mis   = in_is_load & ld_mis;

  // A staged entry is architecturally visible only if it will really write.
  assign st_live  = full & st_wen & ~st_mis & (st_dest != ADDR_W'(REG_ZERO));

  assign rf_w_en         = commit & st_live;
  assign rf_address_d_5  = full ? st_dest : '0;
  assign rf_data_dval_32 = full ? st_data : '0;

  assign byp_s1_hit    = st_live & (st_dest == byp_s1_addr_5);
  assign byp_s2_hit    = st_live & (st_dest == byp_s2_addr_5);
  assign byp_s1_val_32 = byp_s1_hit ? st_data : '0;
  assign byp_s2_val_32 = byp_s2_hit ? st_data : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= EMPTY;
      st_dest         <= '0;
      st_wen          <= 1'b0;
      st_mis          <= 1'b0;
      st_data         <= '0;
      retire_count_32 <= '0;
      misalign_err    <= 1'b0;
    end else begin
      if (accept) begin
        state   <= FULL;
        st_dest <= in_dest_5;
        st_wen  <= in_wen;
        st_mis  <= in_mis;
        st_data <= in_is_load ? ld_data : in_alu_32;
        if (in_mis) misalign_err <= 1'b1;
      end else if (commit) begin
        state <= EMPTY;
      end
      if (commit) retire_count_32 <= retire_count_32 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: randomized and directed stimulus against a reference model.
module tb_writeback_stage;

  typedef struct {
    logic [4:0]  dest;
    logic        wen;
    logic        mis;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_dest_5;
  logic        in_wen;
  logic        in_is_load;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [1:0]  in_addr_lo_2;
  logic [31:0] in_alu_32;
  logic [31:0] in_mem_32;
  logic        wb_hold;
  logic [4:0]  rf_address_d_5;
  logic [31:0] rf_data_dval_32;
  logic        rf_w_en;
  logic [4:0]  byp_s1_addr_5;
  logic [4:0]  byp_s2_addr_5;
  logic        byp_s1_hit;
  logic [31:0] byp_s1_val_32;
  logic        byp_s2_hit;
  logic [31:0] byp_s2_val_32;
  logic [31:0] retire_count_32;
  logic        misalign_err;

  logic        w_in_ready, w_rf_w_en, w_s1_hit, w_s2_hit, w_misalign_err;
  logic [4:0]  w_rf_addr;
  logic [31:0] w_rf_data, w_s1_val, w_s2_val;
  logic [3:0]  w_retire;

  int unsigned nchecks = 0;
  int unsigned nerr    = 0;
  int unsigned mcount  = 0;
  logic        msticky = 1'b0;
  exp_t        q[$];
  logic [4:0]  last_dest = 5'd1;

  writeback_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest_5(in_dest_5), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo_2(in_addr_lo_2),
    .in_alu_32(in_alu_32), .in_mem_32(in_mem_32), .wb_hold(wb_hold),
    .rf_address_d_5(rf_address_d_5), .rf_data_dval_32(rf_data_dval_32), .rf_w_en(rf_w_en),
    .byp_s1_addr_5(byp_s1_addr_5), .byp_s2_addr_5(byp_s2_addr_5),
    .byp_s1_hit(byp_s1_hit), .byp_s1_val_32(byp_s1_val_32),
    .byp_s2_hit(byp_s2_hit), .byp_s2_val_32(byp_s2_val_32),
    .retire_count_32(retire_count_32), .misalign_err(misalign_err)
  );

  // Narrow-counter instance, sharing the stimulus, to observe counter wrap.
  writeback_stage #(.CNT_W(4)) dut_w (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_dest_5(in_dest_5), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo_2(in_addr_lo_2),
    .in_alu_32(in_alu_32), .in_mem_32(in_mem_32), .wb_hold(wb_hold),
    .rf_address_d_5(w_rf_addr), .rf_data_dval_32(w_rf_data), .rf_w_en(w_rf_w_en),
    .byp_s1_addr_5(byp_s1_addr_5), .byp_s2_addr_5(byp_s2_addr_5),
    .byp_s1_hit(w_s1_hit), .byp_s1_val_32(w_s1_val),
    .byp_s2_hit(w_s2_hit), .byp_s2_val_32(w_s2_val),
    .retire_count_32(w_retire), .misalign_err(w_misalign_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result from the architectural load rules.
  function automatic exp_t model(input logic [4:0] dest, input logic wen, input logic ld,
                                 input logic [1:0] size, input logic uns, input logic [1:0] lo,
                                 input logic [31:0] alu, input logic [31:0] mem);
    exp_t e;
    logic [31:0] v;
    e.dest = dest; e.wen = wen; e.mis = 1'b0; e.data = alu;
    if (ld) begin
      if (size == 2'd0) begin
        v = (mem >> (8 * int'(lo))) & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v = (mem >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        e.mis = (int'(lo) % 2) != 0;
      end else begin
        v = mem;
        e.mis = (lo != 2'd0);
      end
      e.data = v;
    end
    return e;
  endfunction

  task automatic set_in(input logic v, input logic [4:0] dest, input logic wen, input logic ld,
                        input logic [1:0] size, input logic uns, input logic [1:0] lo,
                        input logic [31:0] alu, input logic [31:0] mem, input logic hold,
                        input logic [4:0] b1, input logic [4:0] b2);
    in_valid = v; in_dest_5 = dest; in_wen = wen; in_is_load = ld; in_ld_size = size;
    in_ld_unsigned = uns; in_addr_lo_2 = lo; in_alu_32 = alu; in_mem_32 = mem;
    wb_hold = hold; byp_s1_addr_5 = b1; byp_s2_addr_5 = b2;
  endtask

  task automatic idle(input logic hold, input logic [4:0] b1, input logic [4:0] b2);
    set_in(1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0, hold, b1, b2);
  endtask

  // Issue one cycle; push expected result when the handshake completes.
  task automatic tick();
    logic acc;
    exp_t e;
    @(negedge clock);
    acc = in_valid && in_ready;
    @(posedge clock);
    if (acc && reset_n) begin
      e = model(in_dest_5, in_wen, in_is_load, in_ld_size, in_ld_unsigned, in_addr_lo_2,
                in_alu_32, in_mem_32);
      q.push_back(e);
      if (e.mis) msticky = 1'b1;
      last_dest = in_dest_5;
    end
    #1;
  endtask

  // Monitor: compare DUT outputs against the staged expected entry every cycle.
  exp_t m_e;
  logic m_full, m_wr, m_h1, m_h2;
  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_rf_w_en", rf_w_en, 0);
      check("rst_rf_addr", rf_address_d_5, 0);
      check("rst_rf_data", rf_data_dval_32, 0);
      check("rst_byp_hits", {byp_s1_hit, byp_s2_hit}, 0);
      check("rst_count", retire_count_32, 0);
      check("rst_misalign", misalign_err, 0);
    end else begin
      m_full = (q.size() != 0);
      check("in_ready", in_ready, !m_full || !wb_hold);
      if (m_full) begin
        m_e  = q[0];
        m_wr = m_e.wen && !m_e.mis && (m_e.dest != 5'd0);
        m_h1 = m_wr && (m_e.dest == byp_s1_addr_5);
        m_h2 = m_wr && (m_e.dest == byp_s2_addr_5);
        check("rf_w_en", rf_w_en, m_wr && !wb_hold);
        check("rf_addr", rf_address_d_5, m_e.dest);
        check("rf_data", rf_data_dval_32, m_e.data);
        check("byp_s1_hit", byp_s1_hit, m_h1);
        check("byp_s2_hit", byp_s2_hit, m_h2);
        check("byp_s1_val", byp_s1_val_32, m_h1 ? m_e.data : 32'd0);
        check("byp_s2_val", byp_s2_val_32, m_h2 ? m_e.data : 32'd0);
      end else begin
        check("idle_rf_w_en", rf_w_en, 0);
        check("idle_rf_addr", rf_address_d_5, 0);
        check("idle_rf_data", rf_data_dval_32, 0);
        check("idle_byp", {byp_s1_hit, byp_s2_hit, byp_s1_val_32 | byp_s2_val_32}, 0);
      end
      check("retire_count", retire_count_32, mcount);
      check("retire_count_wrap4", 32'(w_retire), mcount % 16);
      check("misalign_err", misalign_err, msticky);
      if (m_full && !wb_hold) begin
        void'(q.pop_front());
        mcount++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle(1'b0, 5'd0, 5'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;

    // ALU write to r3
    set_in(1, 5'd3, 1, 0, 2'd0, 0, 2'd0, 32'h1234, 32'h0, 0, 5'd0, 5'd0);
    tick();
    idle(0, 5'd3, 5'd0);
    #3;
    check("alu_wen", rf_w_en, 1);
    check("alu_addr", rf_address_d_5, 3);
    check("alu_data", rf_data_dval_32, 32'h1234);
    tick(); #3;
    check("alu_count", retire_count_32, 1);

    // r0 suppression
    set_in(1, 5'd0, 1, 0, 2'd0, 0, 2'd0, 32'h55, 32'h0, 0, 5'd0, 5'd0);
    tick();
    idle(0, 5'd0, 5'd0);
    #3;
    check("r0_wen", rf_w_en, 0);
    check("r0_hit", byp_s1_hit, 0);
    tick(); #3;
    check("r0_count", retire_count_32, 2);

    // loads from 0x80FF7F01
    set_in(1, 5'd10, 1, 1, 2'd0, 0, 2'd1, 32'hDEAD, 32'h80FF7F01, 0, 5'd0, 5'd0);
    tick(); idle(0, 5'd0, 5'd0); #3;
    check("lb_lo1", rf_data_dval_32, 32'h0000007F);
    tick();
    set_in(1, 5'd10, 1, 1, 2'd0, 0, 2'd3, 32'hDEAD, 32'h80FF7F01, 0, 5'd0, 5'd0);
    tick(); idle(0, 5'd0, 5'd0); #3;
    check("lb_lo3", rf_data_dval_32, 32'hFFFFFF80);
    tick();
    set_in(1, 5'd10, 1, 1, 2'd1, 1, 2'd2, 32'hDEAD, 32'h80FF7F01, 0, 5'd0, 5'd0);
    tick(); idle(0, 5'd0, 5'd0); #3;
    check("lhu_lo2", rf_data_dval_32, 32'h000080FF);
    tick();
    set_in(1, 5'd10, 1, 1, 2'd2, 0, 2'd2, 32'hDEAD, 32'h80FF7F01, 0, 5'd10, 5'd0);
    tick(); idle(0, 5'd10, 5'd0); #3;
    check("lw_mis_wen", rf_w_en, 0);
    check("lw_mis_hit", byp_s1_hit, 0);
    check("lw_mis_flag", misalign_err, 1);
    tick();

    // back-to-back: three writes in three consecutive cycles
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_in(1, 5'(11 + i), 1, 0, 2'd0, 0, 2'd0, 32'(100 + i), 32'h0, 0, 5'd0, 5'd0);
      else idle(0, 5'd0, 5'd0);
      if (i > 0) begin
        #3;
        check("b2b_wen", rf_w_en, 1);
        check("b2b_addr", rf_address_d_5, 5'(10 + i));
      end
      tick();
    end

    // hold for two cycles with a new entry waiting, then replace on release
    set_in(1, 5'd7, 1, 0, 2'd0, 0, 2'd0, 32'hCAFE, 32'h0, 0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 5'd20, 1, 0, 2'd0, 0, 2'd0, 32'hBEEF, 32'h0, 1, 5'd7, 5'd8);
      #3;
      check("hold_ready", in_ready, 0);
      check("hold_wen", rf_w_en, 0);
      check("hold_s1_hit", byp_s1_hit, 1);
      check("hold_s1_val", byp_s1_val_32, 32'hCAFE);
      check("hold_s2_hit", byp_s2_hit, 0);
      tick();
    end
    set_in(1, 5'd20, 1, 0, 2'd0, 0, 2'd0, 32'hBEEF, 32'h0, 0, 5'd7, 5'd8);
    #3;
    check("release_wen", rf_w_en, 1);
    check("release_data", rf_data_dval_32, 32'hCAFE);
    tick();
    idle(0, 5'd20, 5'd0);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 10) < 7, 5'($urandom), ($urandom % 4) != 0, $urandom % 2,
             2'($urandom), $urandom % 2, 2'($urandom), $urandom, $urandom,
             ($urandom % 5) == 0,
             ($urandom % 2) ? last_dest : 5'($urandom),
             ($urandom % 3) == 0 ? last_dest : 5'($urandom));
      tick();
    end
    idle(0, 5'd0, 5'd0);
    repeat (2) tick();

    // asynchronous reset with a FULL entry
    set_in(1, 5'd5, 1, 0, 2'd0, 0, 2'd0, 32'h55, 32'h0, 0, 5'd5, 5'd0);
    tick();
    idle(0, 5'd5, 5'd0);
    #1 reset_n = 1'b0;
    q.delete(); mcount = 0; msticky = 1'b0;
    #1;
    check("async_wen", rf_w_en, 0);
    check("async_addr", rf_address_d_5, 0);
    check("async_data", rf_data_dval_32, 0);
    check("async_hit", byp_s1_hit, 0);
    check("async_count", retire_count_32, 0);
    check("async_count4", 32'(w_retire), 0);
    check("async_ready", in_ready, 1);
    check("async_mis", misalign_err, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
